// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_e   : responder FSM state encoding (2 bits)
//   req_t     : captured request payload (write flag, byte address, store data)
//   idx_width : word-index width for a given memory depth
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_LSB   = 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store port between the datapath (master) and the data memory (slave).
//   MemReq/MemWrite/ALUResult/WriteData : request, driven by the master
//   ReadData/MemReady/MemErr            : response, driven by the slave
interface dmem_if;

  logic        MemReq;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;

  modport master (
    output MemReq, MemWrite, ALUResult, WriteData,
    input  ReadData, MemReady, MemErr
  );

  modport slave (
    input  MemReq, MemWrite, ALUResult, WriteData,
    output ReadData, MemReady, MemErr
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word array: synchronous write, combinational read, no reset.
//   clk  : write clock
//   we   : write enable
//   addr : word index
//   wd   : write data
//   rd   : read data at addr
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int unsigned IDX_W      = idx_width(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wd;
  end

  assign rd = r_mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with configurable wait states and fault detection.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : load/store port (slave side); MemReady pulses for one cycle per
//           access, MemErr flags misaligned/out-of-range accesses, ReadData
//           carries load data during the MemReady cycle only.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int unsigned    IDX_W    = idx_width(DEPTH_WORDS);
  localparam logic [32:0]    SPAN     = 33'(DEPTH_WORDS * WORD_BYTES);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_WAIT = 2'(WAIT);
  localparam logic [1:0] S_RESP = 2'(RESP);

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  req_t             r_req, w_req_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_err, w_err_nxt;
  logic [31:0]      r_rdata, w_rdata_nxt;

  logic [31:0]      w_addr;
  logic [31:0]      w_off;
  logic             w_fault;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_ram_rd;
  logic             w_we;

  // In IDLE the live bus address is decoded so a zero-wait access can enter
  // RESP straight away; afterwards only the captured address is used.
  assign w_addr  = (r_state == S_IDLE) ? bus.ALUResult : r_req.addr;
  assign w_off   = w_addr - BASE_ADDR;
  assign w_fault = (w_addr[ADDR_LSB-1:0] != '0) ||
                   (w_addr < BASE_ADDR)          ||
                   ({1'b0, w_off} >= SPAN);
  assign w_idx   = w_off[ADDR_LSB +: IDX_W];

  // Store commits on the edge that ends RESP; a faulting store never writes.
  assign w_we = (r_state == S_RESP) && r_req.write && !r_err;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (w_we),
    .addr (w_idx),
    .wd   (r_req.wdata),
    .rd   (w_ram_rd)
  );

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_ready_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.MemReq) begin
          w_req_nxt.write = bus.MemWrite;
          w_req_nxt.addr  = bus.ALUResult;
          w_req_nxt.wdata = bus.WriteData;
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Response fields are prepared on the edge entering RESP. RAM cannot
    // change between that edge and RESP, so sampling load data early is safe.
    if (w_state_nxt == S_RESP) begin
      w_ready_nxt = 1'b1;
      w_err_nxt   = w_fault;
      w_rdata_nxt = (!w_req_nxt.write && !w_fault) ? w_ram_rd : '0;
    end
  end

  // State, counter, capture and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign bus.MemReady = r_ready;
  assign bus.MemErr   = r_err;
  assign bus.ReadData = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder.
// Instance A: WAIT_CYCLES=2 (directed + random vs. reference model).
// Instance B: WAIT_CYCLES=0 (back-to-back throughput).
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WA    = 2;
  localparam longint unsigned BASE = 0;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory for instance A: contents plus "has been written" flags.
  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];

  dmem_if a_if ();
  dmem_if b_if ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WA),
    .BASE_ADDR   (32'h0000_0000)
  ) u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (a_if.slave)
  );

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (0),
    .BASE_ADDR   (32'h0000_0000)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (b_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_fault(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    return (x % 4 != 0) || (x < BASE) || (x >= BASE + DEPTH * 4);
  endfunction

  // One access on instance A; checks latency, pulse width, error and data.
  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input string tag);
    int          lat;
    bit          flt;
    int          idx;
    flt = exp_fault(addr);
    idx = int'((longint'(addr) - BASE) / 4);
    @(negedge clk);
    a_if.MemReq    = 1'b1;
    a_if.MemWrite  = we;
    a_if.ALUResult = addr;
    a_if.WriteData = wd;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the responder must use captured values.
    a_if.MemReq    = 1'b0;
    a_if.MemWrite  = 1'($urandom);
    a_if.ALUResult = $urandom;
    a_if.WriteData = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!a_if.MemReady && lat < 40);
    check($sformatf("%s latency", tag), 32'(lat), 32'(WA + 1));
    check($sformatf("%s err", tag), 32'(a_if.MemErr), 32'(flt));
    if (flt)
      check($sformatf("%s rdata_fault", tag), a_if.ReadData, 32'h0);
    else if (!we && known[idx])
      check($sformatf("%s rdata", tag), a_if.ReadData, model_mem[idx]);
    @(negedge clk);
    check($sformatf("%s ready_pulse", tag), 32'(a_if.MemReady), 32'h0);
    check($sformatf("%s idle_rdata", tag), a_if.ReadData, 32'h0);
    if (we && !flt) begin
      model_mem[idx] = wd;
      known[idx]     = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ops_addr [4];
    logic        ops_we   [4];
    logic [31:0] ops_wd   [4];
    logic [31:0] a;
    int          lat;

    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    a_if.MemReq = 1'b0; a_if.MemWrite = 1'b0; a_if.ALUResult = '0; a_if.WriteData = '0;
    b_if.MemReq = 1'b0; b_if.MemWrite = 1'b0; b_if.ALUResult = '0; b_if.WriteData = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(a_if.MemReady), 32'h0);
    check("rst err",   32'(a_if.MemErr),   32'h0);
    check("rst rdata", a_if.ReadData,      32'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Idle for 10 cycles with MemReq low
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d ready", i), 32'(a_if.MemReady), 32'h0);
      check($sformatf("idle%0d err", i),   32'(a_if.MemErr),   32'h0);
      check($sformatf("idle%0d rdata", i), a_if.ReadData,      32'h0);
    end

    // Store then load, misaligned store, boundary words
    txn_a(1'b1, 32'h10, 32'hDEADBEEF, "st10");
    txn_a(1'b0, 32'h10, 32'h0,        "ld10");
    check("ld10 const", a_if.ReadData == 32'h0 ? model_mem[4] : 32'h0, 32'hDEADBEEF);
    txn_a(1'b1, 32'h13, 32'h12345678, "st13_mis");
    txn_a(1'b0, 32'h10, 32'h0,        "ld10_after_mis");
    txn_a(1'b1, 32'hFC, 32'h0F0F0F0F, "stFC");
    txn_a(1'b0, 32'hFC, 32'h0,        "ldFC");
    txn_a(1'b1, 32'h100, 32'h55555555, "st100_oor");
    txn_a(1'b0, 32'h100, 32'h0,        "ld100_oor");
    txn_a(1'b0, 32'hFC,  32'h0,        "ldFC_unchanged");
    txn_a(1'b0, 32'hFFFF_FFFC, 32'h0,  "ld_top_oor");

    // Reset during WAIT of a store: store discarded
    txn_a(1'b1, 32'h20, 32'hAAAA0000, "st20_prior");
    @(negedge clk);
    a_if.MemReq = 1'b1; a_if.MemWrite = 1'b1;
    a_if.ALUResult = 32'h20; a_if.WriteData = 32'h5555FFFF;
    @(posedge clk);
    #1 a_if.MemReq = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    check("rstwait ready", 32'(a_if.MemReady), 32'h0);
    check("rstwait err",   32'(a_if.MemErr),   32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rstwait quiet%0d", i), 32'(a_if.MemReady), 32'h0);
    end
    txn_a(1'b0, 32'h20, 32'h0, "ld20_after_rst");

    // Reset during RESP of a store: ready drops at once, store discarded
    txn_a(1'b1, 32'h24, 32'h11110000, "st24_prior");
    @(negedge clk);
    a_if.MemReq = 1'b1; a_if.MemWrite = 1'b1;
    a_if.ALUResult = 32'h24; a_if.WriteData = 32'h99999999;
    @(posedge clk);
    #1 a_if.MemReq = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!a_if.MemReady && lat < 40);
    check("rstresp latency", 32'(lat), 32'(WA + 1));
    rst_a = 1'b1;
    #1;
    check("rstresp ready", 32'(a_if.MemReady), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    txn_a(1'b0, 32'h24, 32'h0, "ld24_after_rst");

    // Randomized accesses against the reference model
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: a = 32'($urandom_range(0, 15)) << 2;
        3:       a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        4:       a = 32'h100 + (32'($urandom_range(0, 1000)) << 2);
        5:       a = 32'hFC;
        default: a = 32'hFFFF_FF00 | (32'($urandom_range(0, 63)) << 2);
      endcase
      txn_a(1'($urandom), a, $urandom, $sformatf("rnd%0d", t));
    end

    // Instance B: zero wait states, back-to-back with MemReq held high
    ops_we[0] = 1'b1; ops_addr[0] = 32'h0; ops_wd[0] = 32'hCAFE0001;
    ops_we[1] = 1'b1; ops_addr[1] = 32'h4; ops_wd[1] = 32'h0BAD0002;
    ops_we[2] = 1'b0; ops_addr[2] = 32'h0; ops_wd[2] = 32'h0;
    ops_we[3] = 1'b0; ops_addr[3] = 32'h4; ops_wd[3] = 32'h0;
    @(negedge clk);
    b_if.MemReq = 1'b1; b_if.MemWrite = ops_we[0];
    b_if.ALUResult = ops_addr[0]; b_if.WriteData = ops_wd[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b%0d ready", i), 32'(b_if.MemReady), 32'h1);
      check($sformatf("b2b%0d err", i),   32'(b_if.MemErr),   32'h0);
      if (i == 2) check("b2b2 rdata", b_if.ReadData, 32'hCAFE0001);
      if (i == 3) check("b2b3 rdata", b_if.ReadData, 32'h0BAD0002);
      if (i < 3) begin
        b_if.MemWrite = ops_we[i+1]; b_if.ALUResult = ops_addr[i+1];
        b_if.WriteData = ops_wd[i+1];
      end else begin
        b_if.MemReq = 1'b0;
      end
      @(negedge clk);
      check($sformatf("b2b%0d gap", i), 32'(b_if.MemReady), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the processor's load/store port.
- Accepts word read/write requests carrying address (ALU result) and store data from the datapath.
- Inserts a configurable number of wait states, then returns load data with a one-cycle ready pulse.
- Replaces the zero-latency data memory so the multi-cycle/stall control can be exercised against realistic memory timing.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, at least 4.
- WAIT_CYCLES, 2, wait states between accept and response; 0 to 15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemReq  in  1  request valid; sampled only in IDLE.
- MemWrite  in  1  1 = store, 0 = load; captured with MemReq.
- ALUResult  in  32  byte address of the access.
- WriteData  in  32  store data.
- ReadData  out  32  load data; valid only while MemReady=1.
- MemReady  out  1  one-cycle completion pulse.
- MemErr  out  1  asserted with MemReady when the access faults.

Behaviour:
- Reset values:
  - FSM in IDLE, wait counter 0.
  - ReadData=0, MemReady=0, MemErr=0, capture registers 0.
  - RAM contents are not reset.
- FSM states:
  - IDLE, idle:
    - if MemReq=1, capture MemWrite, ALUResult and WriteData.
    - go to WAIT and load counter = WAIT_CYCLES-1 when WAIT_CYCLES>0; otherwise go directly to RESP.
    - if MemReq=0, stay in IDLE.
  - WAIT:
    - decrement the counter each cycle; go to RESP when it reaches 0.
    - input changes are ignored; only captured values are used.
  - RESP:
    - MemReady=1 for exactly this cycle.
    - a store commits to RAM on the clock edge ending RESP.
    - a load drives ReadData from the RAM word during RESP.
    - always returns to IDLE.
- Latency: MemReady rises WAIT_CYCLES+1 cycles after the accept edge. With WAIT_CYCLES=0, the request is accepted at edge N and MemReady is high in the cycle after edge N.
- Throughput: one transaction per WAIT_CYCLES+2 cycles.
  - If MemReq is still 1 in the IDLE cycle after RESP, it is a new transaction.
  - The requester must drop MemReq on the edge that ends RESP unless it is issuing another access.
- Outside RESP: ReadData=0, MemReady=0, MemErr=0.
- Address decode: word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after range check.
- Fault cases: addr[1:0] != 0, addr < BASE_ADDR, or addr >= BASE_ADDR + DEPTH_WORDS*4.
  - On a fault, RESP asserts MemErr=1 with MemReady=1 and ReadData=0.
  - A faulting store does not modify RAM.
- Last word (index DEPTH_WORDS-1) is legal; the next word address faults, with no wrap-around.
- Reset asserted mid-transaction (WAIT or RESP):
  - immediate return to IDLE, outputs to reset values.
  - a pending store is discarded unless its commit edge has already occurred.
- Load following store to the same address: the load returns the new data, since the store committed before the load was accepted.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}, 2 bits.
  - WORD_BYTES=4.
  - ADDR_LSB=2.
  - function/constant for the index width, $clog2(DEPTH_WORDS).
- Sub-module dmem_ram: single-port synchronous-write, combinational-read word array; ports clk, we, addr, wd, rd; no reset.
- dmem_responder holds the FSM, counter, capture registers, range/alignment check and output muxing.

Test Plan:
- Reset, then idle with MemReq=0 for 10 cycles -> MemReady, MemErr and ReadData stay 0; FSM stays in IDLE.
- WAIT_CYCLES=2: store 32'hDEADBEEF to 0x10, then load 0x10 -> each MemReady pulse is exactly 1 cycle, rising 3 cycles after accept; the load returns 32'hDEADBEEF with MemErr=0.
- Misaligned store to 0x13 with data 32'h12345678, then load 0x10 -> the store responds MemErr=1, ReadData=0; the load still returns 32'hDEADBEEF.
- DEPTH_WORDS=64: load 0xFC succeeds; access to 0x100 -> MemErr=1, ReadData=0, RAM unchanged.
- WAIT_CYCLES=0: back-to-back stores to 0x0 and 0x4 with MemReq held high -> MemReady every 2nd cycle; reading them back returns both values.
- Assert reset during WAIT of a store to 0x20 (prior value 32'hAAAA0000) -> outputs clear immediately, no MemReady; a later load of 0x20 returns 32'hAAAA0000.
